// File: rtl/kf6845_pkg.sv
// Shared types and constants for the KF6845 light pen capture path.
// Entries always carry a 16-bit address so the storage type does not depend on ADDR_WIDTH.
package kf6845_pkg;

  localparam int MAX_ADDR_W = 16;
  localparam int CH_W       = 2;

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [MAX_ADDR_W-1:0] addr;
  } lp_entry_t;

  localparam int ST_OVERFLOW  = 7;
  localparam int ST_EMPTY     = 6;
  localparam int ST_CH_LSB    = 4;
  localparam int ST_COUNT_LSB = 0;
  localparam int ST_COUNT_W   = 4;

  localparam logic [7:0] BUS_IDLE = 8'hFF;

endpackage

// File: rtl/kf6845_light_pen_strobe.sv
// One light pen channel: enable-qualified strobe sampling and rising-edge detection.
// Build with KF6845_LIGHT_PEN_FILTER_EN to require low-high-high before an edge is reported.
module kf6845_light_pen_strobe (
  input  logic clock,
  input  logic reset_n,
  input  logic video_clock_enable,
  input  logic lpstb,
  output logic strobe_edge
);

`ifdef KF6845_LIGHT_PEN_FILTER_EN
  // hist_q[0] is the latest enable sample, hist_q[1] the one before it.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = video_clock_enable ? {hist_q[0], lpstb} : hist_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hist_q <= 2'b11;
    else          hist_q <= hist_d;
  end

  assign strobe_edge = video_clock_enable & ~hist_q[1] & hist_q[0] & lpstb;
`else
  // Resetting high means a strobe already asserted at reset release is not an edge.
  logic prev_q, prev_d;

  always_comb begin
    prev_d = video_clock_enable ? lpstb : prev_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b1;
    else          prev_q <= prev_d;
  end

  assign strobe_edge = video_clock_enable & ~prev_q & lpstb;
`endif

endmodule

// File: rtl/kf6845_light_pen_fifo.sv
// Multi-channel light pen capture into a shared FIFO with status/read mux on the data bus.
// Optional strobe glitch filter: define KF6845_LIGHT_PEN_FILTER_EN.
module kf6845_light_pen_fifo
  import kf6845_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 4,
  parameter int CHANNELS   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  video_clock_enable,
  output logic [7:0]            internal_data_bus_out,
  input  logic                  read_light_pen_h_register,
  input  logic                  read_light_pen_l_register,
  input  logic                  read_light_pen_status_register,
  input  logic [ADDR_WIDTH-1:0] MA,
  input  logic [CHANNELS-1:0]   LPSTB
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CHANNELS-1:0]   edges;
  lp_entry_t             mem_q [DEPTH];
  lp_entry_t             wr_entry, head_entry;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [ST_COUNT_W-1:0] count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  rd_l_q, rd_l_d, rd_s_q, rd_s_d;
  logic [CH_W-1:0]       wr_ch;
  logic                  any_edge, multi_edge, empty, full, pop, wr;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_strobe
    kf6845_light_pen_strobe u_strobe (
      .clock              (clock),
      .reset_n            (reset_n),
      .video_clock_enable (video_clock_enable),
      .lpstb              (LPSTB[i]),
      .strobe_edge        (edges[i])
    );
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (edges[i]) wr_ch = CH_W'(i);
    end
    any_edge   = |edges;
    multi_edge = |(edges & (edges - CHANNELS'(1)));
    empty      = (count_q == '0);
    full       = (count_q == ST_COUNT_W'(DEPTH));
    pop        = rd_l_q & ~read_light_pen_l_register & ~empty;
    // A pop in the same clock frees the slot, so a full FIFO can still accept.
    wr         = any_edge & (~full | pop);
    rd_l_d     = read_light_pen_l_register;
    rd_s_d     = read_light_pen_status_register;
    ovf_d      = multi_edge | (any_edge & full & ~pop) |
                 (ovf_q & ~(rd_s_q & ~read_light_pen_status_register));
    head_d     = pop ? ptr_inc(head_q) : head_q;
    tail_d     = wr  ? ptr_inc(tail_q) : tail_q;
    count_d    = count_q + ST_COUNT_W'(wr) - ST_COUNT_W'(pop);
    wr_entry   = '{ch: wr_ch, addr: MAX_ADDR_W'(MA)};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rd_l_q  <= 1'b0;
      rd_s_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      rd_l_q  <= rd_l_d;
      rd_s_q  <= rd_s_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem_q[tail_q] <= wr_entry;
  end

  assign head_entry = mem_q[head_q];

  always_comb begin
    internal_data_bus_out = BUS_IDLE;
    if (read_light_pen_h_register) begin
      internal_data_bus_out = empty ? 8'h00 : head_entry.addr[15:8];
    end else if (read_light_pen_l_register) begin
      internal_data_bus_out = empty ? 8'h00 : head_entry.addr[7:0];
    end else if (read_light_pen_status_register) begin
      internal_data_bus_out = '0;
      internal_data_bus_out[ST_OVERFLOW] = ovf_q;
      internal_data_bus_out[ST_EMPTY]    = empty;
      internal_data_bus_out[ST_CH_LSB +: CH_W] = empty ? '0 : head_entry.ch;
      internal_data_bus_out[ST_COUNT_LSB +: ST_COUNT_W] = count_q;
    end
  end

endmodule
